// File: rtl/route_compute_stage.sv
// Per-input-port route computation: looks up the head flit's destination
// and tags every flit of the packet with the returned output port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_flit/valid   upstream flit link, in_ready is the accept strobe
//   sel_addr        registered destination, select of the lookup mux
//   tbl_port        lookup mux result for sel_addr (combinational)
//   out_flit/port   downstream flit plus its output port tag
//   out_valid/ready downstream handshake
//   err_dest        pulse: head destination out of range, packet dropped
//   err_proto       pulse: orphan body/tail, or head inside a packet
//   pkt_count       forwarded packets, saturating

module route_compute_stage #(
    parameter int FLIT_WIDTH    = 32,
    parameter int LOG_PORTS_CNT = 3,
    parameter int NODES_CNT     = 1000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [0:FLIT_WIDTH-1]    in_flit,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [0:9]               sel_addr,
    input  logic [0:LOG_PORTS_CNT-1] tbl_port,
    output logic [0:FLIT_WIDTH-1]    out_flit,
    output logic [0:LOG_PORTS_CNT-1] out_port,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_dest,
    output logic                     err_proto,
    output logic [0:CNT_WIDTH-1]     pkt_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FWD,
        DROP
    } state_t;

    state_t                   state;
    logic [0:FLIT_WIDTH-1]    flit_buf;
    logic                     buf_valid;
    logic                     tail_in;
    logic [0:LOG_PORTS_CNT-1] port_r;

    logic       can_take;
    logic       accept;
    logic       emit;
    logic       in_head;
    logic       in_tail;
    logic       buf_tail;
    logic [0:9] in_dest;

    function automatic logic dest_bad(input logic [0:9] d);
        return {22'd0, d} >= NODES_CNT;
    endfunction

    // Type field: bit 1 marks a head (01/11), bit 0 marks a tail (10/11).
    assign in_head  = in_flit[1];
    assign in_tail  = in_flit[0];
    assign buf_tail = flit_buf[0];
    assign in_dest  = in_flit[2:11];

    always_comb begin
        can_take = 1'b0;
        unique case (state)
            IDLE:    can_take = 1'b1;
            LOOKUP:  can_take = 1'b0;
            FWD:     can_take = (!buf_valid || out_ready) && !tail_in;
            DROP:    can_take = 1'b1;
            default: can_take = 1'b0;
        endcase
    end

    assign in_ready  = can_take && !rst;
    assign accept    = in_valid && in_ready;

    assign out_valid = (state == FWD) && buf_valid;
    assign out_flit  = (state == FWD) ? flit_buf : '0;
    assign out_port  = (state == FWD) ? port_r : '0;
    assign emit      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flit_buf  <= '0;
            buf_valid <= 1'b0;
            tail_in   <= 1'b0;
            port_r    <= '0;
            sel_addr  <= '0;
            err_dest  <= 1'b0;
            err_proto <= 1'b0;
            pkt_count <= '0;
        end else begin
            err_dest  <= 1'b0;
            err_proto <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_head) begin
                            flit_buf <= in_flit;
                            tail_in  <= in_tail;
                            sel_addr <= in_dest;
                            // Raised here so the pulse lines up with LOOKUP.
                            err_dest <= dest_bad(in_dest);
                            state    <= LOOKUP;
                        end else begin
                            err_proto <= 1'b1;
                        end
                    end
                end
                LOOKUP: begin
                    port_r <= tbl_port;
                    if (dest_bad(sel_addr)) begin
                        flit_buf <= '0;
                        tail_in  <= 1'b0;
                        state    <= buf_tail ? IDLE : DROP;
                    end else begin
                        buf_valid <= 1'b1;
                        state     <= FWD;
                    end
                end
                FWD: begin
                    // tail_in blocks input, so a tail leaving never
                    // coincides with a new flit arriving.
                    if (emit && buf_tail) begin
                        buf_valid <= 1'b0;
                        tail_in   <= 1'b0;
                        state     <= IDLE;
                        if (pkt_count != '1) begin
                            pkt_count <= pkt_count + CNT_WIDTH'(1);
                        end
                    end else if (accept) begin
                        flit_buf  <= in_flit;
                        buf_valid <= 1'b1;
                        tail_in   <= in_tail;
                        err_proto <= in_head;
                    end else if (emit) begin
                        buf_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if (accept) begin
                        err_proto <= in_head;
                        if (in_tail) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/route_compute_stage.md
Name: route_compute_stage

Overview:
- Per-input-port routing stage; sits directly upstream of the routing-table lookup mux.
- Accepts flits on a valid/ready link and extracts the destination from each head flit.
- Drives that destination as the lookup mux select and registers the returned output port.
- Holds that port for every flit of the packet until the tail, then forwards flits downstream with the port tag attached.

Parameters:
- FLIT_WIDTH, 32, flit width; bits [0:1] type, bits [2:11] destination (head only).
- LOG_PORTS_CNT, 3, width of the output-port code returned by the lookup mux.
- NODES_CNT, 1000, number of valid destinations; legal destinations are 0..NODES_CNT-1.
- CNT_WIDTH, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- in_flit  input  [0:FLIT_WIDTH-1]  incoming flit.
- in_valid  input  1  in_flit valid.
- in_ready  output  1  stage accepts in_flit this cycle.
- sel_addr  output  [0:9]  registered destination driven to the lookup mux select.
- tbl_port  input  [0:LOG_PORTS_CNT-1]  lookup mux output for sel_addr (combinational).
- out_flit  output  [0:FLIT_WIDTH-1]  flit to the switch allocator.
- out_port  output  [0:LOG_PORTS_CNT-1]  output port for out_flit.
- out_valid  output  1  out_flit/out_port valid.
- out_ready  input  1  downstream accepts.
- err_dest  output  1  1-cycle pulse: head destination >= NODES_CNT, packet dropped.
- err_proto  output  1  1-cycle pulse: orphan body/tail in IDLE, or head flit inside a packet.
- pkt_count  output  [0:CNT_WIDTH-1]  forwarded packets, saturating.

Behaviour:
- Flit type encoding: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail).
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_flit and out_port are stable while out_valid && !out_ready.
- Reset (rst high at a clock edge):
  - State = IDLE; buffer empty.
  - in_ready=0 during the reset cycle, 1 afterwards.
  - out_valid=0, out_flit=0, out_port=0, sel_addr=0, err_dest=0, err_proto=0, pkt_count=0.
  - Reset mid-packet discards the buffered flit and the held route.
- Storage: one flit buffer (buf, buf_valid) and a route register (port_r).
  - out_flit=buf, out_port=port_r, out_valid=buf_valid only in state FWD.
- States:
  - IDLE:
    - in_ready=1.
    - Head/single accepted: buf<=flit, sel_addr<=flit[2:11]; go to LOOKUP.
    - Body/tail accepted: discarded, err_proto pulses, stay in IDLE.
  - LOOKUP (exactly 1 cycle):
    - in_ready=0.
    - port_r<=tbl_port.
    - If sel_addr >= NODES_CNT: err_dest pulses, buf cleared. If the buffered flit is single, go to IDLE; otherwise go to DROP.
    - Else: buf_valid=1, go to FWD.
  - FWD:
    - in_ready = (!buf_valid || out_ready) && !tail_in.
    - tail_in sets when a tail or single flit enters buf.
    - An accepted flit replaces buf in the same cycle the previous flit leaves, giving 1 flit/cycle throughput.
    - A head flit accepted in FWD is forwarded unchanged as a body flit and err_proto pulses.
    - Output handshake of a tail/single flit: pkt_count+1 (saturating at all-ones), tail_in clears, buf_valid=0, go to IDLE.
  - DROP:
    - in_ready=1, out_valid=0.
    - Flits are accepted and discarded.
    - Tail accepted: go to IDLE.
    - A head accepted in DROP is discarded and err_proto pulses.
- Latency: head accepted at cycle T → sel_addr valid at T+1 → out_valid at T+2. Each body flit adds 1 cycle.
- Next packet:
  - A new head is not accepted in the cycle the previous tail leaves; in_ready rises in IDLE on the following cycle.
  - Minimum inter-packet gap at the input: 2 cycles after the tail is accepted (drain + IDLE).
- sel_addr holds its value outside LOOKUP.
- tbl_port is sampled only in LOOKUP.

Test Plan:
1. Route and forward: table maps dest 5→port 3; send head(dest=5), body, tail back-to-back with out_ready=1 → out_valid at head+2; three flits emitted on consecutive cycles, all with out_port=3; pkt_count=1; in_ready=1 one cycle after the tail drains.
2. Backpressure: same packet with out_ready=0 for 4 cycles after the first output → out_flit/out_port unchanged; in_ready=0 while buf is full; no flit lost or duplicated.
3. Invalid destination: head dest=1000 then body, tail → err_dest pulses once in the LOOKUP cycle; out_valid never asserts; returns to IDLE after the tail; pkt_count unchanged. Single flit with dest=1023 → err_dest pulse, back to IDLE the cycle after LOOKUP.
4. Protocol errors: body flit in IDLE → err_proto 1 cycle, no output; head inside a packet → forwarded with port_r, err_proto 1 cycle.
5. Reset mid-packet: rst high after head+body are accepted → next cycle out_valid=0, pkt_count=0, state IDLE; a new head(dest=7, port 1) then routes correctly.
6. Counter saturation: preload or drive pkt_count to 0xFFFF, forward one more single-flit packet → pkt_count stays 0xFFFF.
